// File: rtl/pwconv_input_reader.sv
// Ping-pong frame buffer between the depthwise stage and the pointwise datapath:
// accepts 4-pixel frames and replays them one pixel vector per beat.
// Optional build macro PWCONV_IN_RELU_EN clamps negative output lanes to zero.
module pwconv_input_reader #(
  parameter int CH   = 32,
  parameter int DW   = 8,
  parameter int NPIX = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data0,
  input  logic [CH*DW-1:0] in_data1,
  input  logic [CH*DW-1:0] in_data2,
  input  logic [CH*DW-1:0] in_data3,
  input  logic [3:0]       in_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [1:0]       out_pix,
  output logic [3:0]       out_pos,
  output logic             out_last,
  output logic             busy
);

  localparam int VW = CH * DW;

  logic [VW-1:0] mem_data [2][NPIX];
  logic [3:0]    mem_pos  [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] pix;

  logic accept;
  logic beat;
  logic pop;

  assign in_ready  = (count < 2'd2) && !rst_b;
  assign out_valid = (count != 2'd0);
  assign busy      = out_valid;
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (pix == 2'd3);

  assign out_pix   = pix;
  assign out_last  = out_valid && (pix == 2'd3);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr][0] <= in_data0;
      mem_data[wr_ptr][1] <= in_data1;
      mem_data[wr_ptr][2] <= in_data2;
      mem_data[wr_ptr][3] <= in_data3;
      mem_pos[wr_ptr]     <= in_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      pix    <= '0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (beat)   pix    <= pix + 2'd1;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared, so data/pos are forced to zero while empty
  // to give defined values after reset.
  always_comb begin
    logic [VW-1:0] raw;
    logic [DW-1:0] lane;
    raw      = mem_data[rd_ptr][pix];
    out_data = '0;
    out_pos  = out_valid ? mem_pos[rd_ptr] : 4'd0;
    for (int unsigned i = 0; i < CH; i++) begin
      lane = raw[i*DW +: DW];
`ifdef PWCONV_IN_RELU_EN
      if (lane[DW-1]) lane = '0;
`endif
      out_data[i*DW +: DW] = out_valid ? lane : '0;
    end
  end

endmodule

// File: tb/tb_pwconv_input_reader.sv
// Randomised bench for pwconv_input_reader: a frame-queue reference model is
// compared every cycle, plus directed scenarios pinned by literal expectations.
module tb_pwconv_input_reader;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_pos;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [1:0]   out_pix;
  logic [3:0]   out_pos;
  logic         out_last;
  logic         busy;

  int cmp_n = 0;
  int err_n = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic [3:0]    pos;
    logic [1023:0] d;
  } frame_t;

  frame_t q[$];
  int     mpix = 0;

  pwconv_input_reader #(.CH(32), .DW(8), .NPIX(4)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_pos(in_pos), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pix(out_pix), .out_pos(out_pos), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] relu_v(input logic [255:0] v);
    logic [255:0] r;
    r = v;
`ifdef PWCONV_IN_RELU_EN
    for (int c = 0; c < 32; c++)
      if (v[c*8+7]) r[c*8 +: 8] = 8'h00;
`endif
    return r;
  endfunction

  // Reference model: a FIFO of whole frames plus the index of the next pixel.
  always @(negedge clk) begin
    bit     exp_ready, exp_valid, acc, bt;
    frame_t f;
    exp_ready = (q.size() < 2) && !rst_b;
    exp_valid = (q.size() != 0);
    if (check_en) begin
      chk("in_ready",  {255'd0, in_ready},  {255'd0, exp_ready});
      chk("out_valid", {255'd0, out_valid}, {255'd0, exp_valid});
      chk("busy",      {255'd0, busy},      {255'd0, exp_valid});
      if (exp_valid) begin
        chk("out_pix",  {254'd0, out_pix},  256'(mpix));
        chk("out_pos",  {252'd0, out_pos},  {252'd0, q[0].pos});
        chk("out_data", out_data, relu_v(q[0].d[mpix*256 +: 256]));
        chk("out_last", {255'd0, out_last}, {255'd0, (mpix == 3)});
      end
    end
    if (rst_b) begin
      q.delete();
      mpix = 0;
    end else begin
      acc = in_valid && exp_ready;
      bt  = out_ready && exp_valid;
      if (bt) begin
        if (mpix == 3) begin
          void'(q.pop_front());
          mpix = 0;
        end else begin
          mpix++;
        end
      end
      if (acc) begin
        f.pos = in_pos;
        f.d   = {in_data3, in_data2, in_data1, in_data0};
        q.push_back(f);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [1023:0] d, input logic [3:0] pos);
    {in_data3, in_data2, in_data1, in_data0} = d;
    in_pos = pos;
  endtask

  function automatic logic [1023:0] rand_frame();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Offers a frame and returns just after the edge that accepted it.
  task automatic send(input logic [1023:0] d, input logic [3:0] pos);
    bit r;
    set_frame(d, pos);
    in_valid = 1'b1;
    r = 1'b0;
    for (int i = 0; i < 50 && !r; i++) begin
      @(negedge clk);
      r = in_ready;
      step();
    end
    if (!r) chk("send_timeout", 256'd0, 256'd1);
  endtask

  task automatic drain();
    bit b;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    b = 1'b1;
    for (int i = 0; i < 50 && b; i++) begin
      @(negedge clk);
      b = busy;
      step();
    end
    if (b) chk("drain_timeout", 256'd0, 256'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] pat;
    logic [1023:0] rl;
    logic [7:0]    b;
    logic [7:0]    exp_l0;
    logic [31:0]   exp_relu;
`ifdef PWCONV_IN_RELU_EN
    exp_l0   = 8'h00;
    exp_relu = 32'h7F000000;
`else
    exp_l0   = 8'hC0;
    exp_relu = 32'h7F00FF80;
`endif
    rst_b = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_frame('0, 4'd0);
    step();
    check_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_in_ready",  {255'd0, in_ready},  256'd0);
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_out_last",  {255'd0, out_last},  256'd0);
    chk("rst_busy",      {255'd0, busy},      256'd0);
    chk("rst_out_pix",   {254'd0, out_pix},   256'd0);
    chk("rst_out_pos",   {252'd0, out_pos},   256'd0);
    chk("rst_out_data",  out_data,            256'd0);
    step();
    rst_b = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {255'd0, in_ready}, 256'd1);
    step();

    // Single frame with lane c of pixel p = p*32+c-64, pos 5
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 32; c++) begin
        b = 8'(p*32 + c - 64);
        pat[p*256 + c*8 +: 8] = b;
      end
    out_ready = 1'b1;
    send(pat, 4'd5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sf_valid", {255'd0, out_valid}, 256'd1);
    chk("sf_pix0",  {254'd0, out_pix},   256'd0);
    chk("sf_pos",   {252'd0, out_pos},   256'd5);
    chk("sf_lane0", {248'd0, out_data[7:0]}, {248'd0, exp_l0});
    step(); step(); step();
    @(negedge clk);
    chk("sf_pix3",   {254'd0, out_pix},  256'd3);
    chk("sf_last",   {255'd0, out_last}, 256'd1);
    chk("sf_lane31", {248'd0, out_data[255:248]}, 256'h3F);
    step();
    @(negedge clk);
    chk("sf_done_valid", {255'd0, out_valid}, 256'd0);
    chk("sf_done_busy",  {255'd0, busy},      256'd0);
    step();

    // Back-to-back frames with in_valid held high
    for (int i = 0; i < 3; i++) send(rand_frame(), 4'($urandom_range(0, 8)));
    drain();

    // Backpressure for 10 cycles
    out_ready = 1'b0;
    send(rand_frame(), 4'd7);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    chk("bp_pix", {254'd0, out_pix}, 256'd0);
    step();
    drain();

    // Accept coinciding with the pix-3 pop
    out_ready = 1'b1;
    send(rand_frame(), 4'd1);
    in_valid = 1'b0;
    step(); step(); step();
    send(rand_frame(), 4'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sim_pix",  {254'd0, out_pix}, 256'd0);
    chk("sim_pos",  {252'd0, out_pos}, 256'd2);
    chk("sim_busy", {255'd0, busy},    256'd1);
    step();
    drain();

    // Reset with pix = 2
    send(rand_frame(), 4'd3);
    in_valid = 1'b0;
    step(); step();
    rst_b = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {255'd0, in_ready}, 256'd0);
    step();
    rst_b = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid",    {255'd0, out_valid}, 256'd0);
    chk("mid_rst_in_ready1", {255'd0, in_ready}, 256'd1);
    step();
    send(rand_frame(), 4'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_pix0", {254'd0, out_pix}, 256'd0);
    step();
    drain();

    // Lanes -128, -1, 0, 127
    rl = rand_frame();
    rl[31:0] = 32'h7F00FF80;
    send(rl, 4'd8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("relu_lanes", {224'd0, out_data[31:0]}, {224'd0, exp_relu});
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_frame(rand_frame(), 4'($urandom_range(0, 8)));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_b     = ($urandom_range(0, 99) == 0);
      step();
    end
    rst_b = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
